// File: rtl/wire_monitor_n.sv
// wire_monitor_n
//   N-channel wire debouncer for the bomb-defusal front end. Each raw wire is
//   passed through a two-flop synchroniser and a per-channel stability filter.
//   Accepted level changes produce one-cycle cut/mend pulses. While armed, cut
//   events are latched into a sticky mask, and the first cut index is captured.
//   Rejected glitches on all channels are counted in a saturating counter.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous reset, active-low
//   wire_in         raw asynchronous wire levels
//   arm             1 = latch cut events into status
//   clr             synchronous clear of cut_mask / first_cut_* / glitch_cnt
//   wire_out        debounced wire levels
//   cut_pulse       1-cycle pulse when wire_out[i] changes to CUT_LEVEL
//   mend_pulse      1-cycle pulse when wire_out[i] changes away from CUT_LEVEL
//   cut_mask        sticky mask of armed cuts
//   first_cut_valid sticky flag, set by the first armed cut
//   first_cut_idx   index of the first armed cut (lowest index on ties)
//   glitch_cnt      saturating count of rejected glitches

module wire_monitor_n #(
    parameter int N_CH          = 6,
    parameter int CLK_HZ        = 50_000_000,
    parameter int STABLE_MS     = 2,
    parameter int STABLE_CYCLES = (CLK_HZ / 1000) * STABLE_MS,
    parameter bit CUT_LEVEL     = 1'b0,
    parameter int GLITCH_W      = 8,
    localparam int IDX_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     wire_in,
    input  logic                arm,
    input  logic                clr,
    output logic [N_CH-1:0]     wire_out,
    output logic [N_CH-1:0]     cut_pulse,
    output logic [N_CH-1:0]     mend_pulse,
    output logic [N_CH-1:0]     cut_mask,
    output logic                first_cut_valid,
    output logic [IDX_W-1:0]    first_cut_idx,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int SUM_W  = $clog2(N_CH + 1);
    localparam int WIDE_W = ((GLITCH_W > SUM_W) ? GLITCH_W : SUM_W) + 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [WIDE_W-1:0] GC_MAX   = WIDE_W'({GLITCH_W{1'b1}});

    logic [N_CH-1:0]   sync1;
    logic [N_CH-1:0]   sync2;
    logic [CNT_W-1:0]  cnt [N_CH];

    logic [N_CH-1:0]   accept;
    logic [N_CH-1:0]   reject;
    logic [N_CH-1:0]   armed_cut;
    logic [SUM_W-1:0]  glitch_sum;
    logic [WIDE_W-1:0] glitch_wide;
    logic [IDX_W-1:0]  lowest_cut;

    // A reject is the synchronised level falling back to the accepted level
    // after at least one mismatching sample.
    always_comb begin
        accept = '0;
        reject = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sync2[i] == wire_out[i]) begin
                reject[i] = (cnt[i] != '0);
            end else begin
                accept[i] = (cnt[i] == CNT_LAST);
            end
        end
    end

    // Saturation is decided on the widened sum so a multi-channel burst near
    // full scale cannot wrap.
    always_comb begin
        glitch_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            glitch_sum = glitch_sum + SUM_W'(reject[i]);
        end
        glitch_wide = WIDE_W'(glitch_cnt) + WIDE_W'(glitch_sum);
    end

    // Descending scan so the lowest armed index is the last one written.
    always_comb begin
        armed_cut  = cut_pulse & {N_CH{arm}};
        lowest_cut = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (armed_cut[i]) begin
                lowest_cut = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= {N_CH{~CUT_LEVEL}};
            sync2      <= {N_CH{~CUT_LEVEL}};
            wire_out   <= {N_CH{~CUT_LEVEL}};
            cut_pulse  <= '0;
            mend_pulse <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= wire_in;
            sync2 <= sync1;
            for (int i = 0; i < N_CH; i++) begin
                cut_pulse[i]  <= accept[i] && (sync2[i] == CUT_LEVEL);
                mend_pulse[i] <= accept[i] && (sync2[i] != CUT_LEVEL);
                if (sync2[i] == wire_out[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    wire_out[i] <= sync2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cut_mask        <= '0;
            first_cut_valid <= 1'b0;
            first_cut_idx   <= '0;
            glitch_cnt      <= '0;
        end else if (clr) begin
            cut_mask        <= '0;
            first_cut_valid <= 1'b0;
            first_cut_idx   <= '0;
            glitch_cnt      <= '0;
        end else begin
            cut_mask <= cut_mask | armed_cut;
            if (!first_cut_valid && (armed_cut != '0)) begin
                first_cut_valid <= 1'b1;
                first_cut_idx   <= lowest_cut;
            end
            if (glitch_wide > GC_MAX) begin
                glitch_cnt <= GLITCH_W'(GC_MAX);
            end else begin
                glitch_cnt <= GLITCH_W'(glitch_wide);
            end
        end
    end

endmodule

// File: tb/tb_wire_monitor_n.sv
module tb_wire_monitor_n;

    localparam int N  = 6;
    localparam int SC = 4;
    localparam int GW = 8;
    localparam int GMAX = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  wire_in = 6'h3F;
    logic          arm = 1'b0;
    logic          clr = 1'b0;
    logic [N-1:0]  wire_out;
    logic [N-1:0]  cut_pulse;
    logic [N-1:0]  mend_pulse;
    logic [N-1:0]  cut_mask;
    logic          first_cut_valid;
    logic [2:0]    first_cut_idx;
    logic [GW-1:0] glitch_cnt;

    int vec  = 0;
    int errs = 0;

    wire_monitor_n #(
        .N_CH(N), .STABLE_CYCLES(SC), .CUT_LEVEL(1'b0), .GLITCH_W(GW)
    ) dut (
        .clk(clk), .rst(rst), .wire_in(wire_in), .arm(arm), .clr(clr),
        .wire_out(wire_out), .cut_pulse(cut_pulse), .mend_pulse(mend_pulse),
        .cut_mask(cut_mask), .first_cut_valid(first_cut_valid),
        .first_cut_idx(first_cut_idx), .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: each channel delays its input by two samples, then
    // tracks how many consecutive samples disagreed with the accepted level.
    bit        m_d1 [N];
    bit        m_d2 [N];
    bit        m_lvl [N];
    int        m_run [N];
    bit [N-1:0] m_cut, m_mend, m_mask;
    bit        m_fv;
    int        m_idx;
    int        m_gc;

    always @(posedge clk) begin : model
        int         g;
        bit [N-1:0] nc, nm;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_d1[i] = 1; m_d2[i] = 1; m_lvl[i] = 1; m_run[i] = 0;
            end
            m_cut = 0; m_mend = 0; m_mask = 0; m_fv = 0; m_idx = 0; m_gc = 0;
        end else begin
            g = 0; nc = 0; nm = 0;
            for (int i = 0; i < N; i++) begin
                if (m_d2[i] == m_lvl[i]) begin
                    if (m_run[i] > 0) g++;
                    m_run[i] = 0;
                end else if (m_run[i] + 1 >= SC) begin
                    m_lvl[i] = m_d2[i];
                    m_run[i] = 0;
                    if (m_d2[i] == 0) nc[i] = 1; else nm[i] = 1;
                end else begin
                    m_run[i]++;
                end
            end
            if (clr) begin
                m_mask = 0; m_fv = 0; m_idx = 0; m_gc = 0;
            end else begin
                if (arm) begin
                    m_mask |= m_cut;
                    if (!m_fv && m_cut != 0) begin
                        m_fv = 1;
                        for (int i = N - 1; i >= 0; i--) if (m_cut[i]) m_idx = i;
                    end
                end
                m_gc = (m_gc + g > GMAX) ? GMAX : m_gc + g;
            end
            m_cut = nc; m_mend = nm;
            for (int i = 0; i < N; i++) begin
                m_d2[i] = m_d1[i];
                m_d1[i] = wire_in[i];
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1; step(); clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; wire_in = 6'h3F; arm = 1'b0; clr = 1'b0;
        step(3);
        vec++;
        if (wire_out !== 6'h3F || cut_pulse !== 0 || mend_pulse !== 0 || cut_mask !== 0 ||
            first_cut_valid !== 0 || first_cut_idx !== 0 || glitch_cnt !== 0) begin
            errs++;
            $display("FAIL reset_state: out=%h cut=%h mend=%h mask=%h fv=%b idx=%0d gc=%0d, need 3f/0/0/0/0/0/0",
                     wire_out, cut_pulse, mend_pulse, cut_mask, first_cut_valid, first_cut_idx, glitch_cnt);
        end
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            vec++;
            if (wire_out !== 6'h3F || cut_pulse !== 0 || mend_pulse !== 0) begin
                errs++;
                $display("FAIL after_release: out=%h cut=%h mend=%h, need 3f/0/0", wire_out, cut_pulse, mend_pulse);
            end
        end
    endtask

    task automatic test_single_cut();
        arm = 1'b1;
        wire_in[2] = 1'b0;
        step(5);
        vec++;
        if (wire_out !== 6'h3F || cut_pulse !== 0) begin
            errs++;
            $display("FAIL cut_early: out=%h cut=%h, need 3f/00", wire_out, cut_pulse);
        end
        step();
        vec++;
        if (wire_out !== 6'h3B || cut_pulse !== 6'h04) begin
            errs++;
            $display("FAIL cut_latency: out=%h cut=%h, need 3b/04", wire_out, cut_pulse);
        end
        step();
        vec++;
        if (cut_pulse !== 0 || cut_mask !== 6'h04 || first_cut_valid !== 1 || first_cut_idx !== 3'd2) begin
            errs++;
            $display("FAIL cut_latch: cut=%h mask=%h fv=%b idx=%0d, need 00/04/1/2",
                     cut_pulse, cut_mask, first_cut_valid, first_cut_idx);
        end
        wire_in[2] = 1'b1;
        step(10);
        vec++;
        if (wire_out !== 6'h3F || cut_mask !== 6'h04) begin
            errs++;
            $display("FAIL mend_keeps_mask: out=%h mask=%h, need 3f/04", wire_out, cut_mask);
        end
        pulse_clr();
    endtask

    task automatic test_glitch();
        pulse_clr();
        for (int r = 0; r < 300; r++) begin
            wire_in[0] = 1'b0; step(3);
            wire_in[0] = 1'b1; step(4);
            vec++;
            if (wire_out !== 6'h3F || cut_pulse !== 0 || mend_pulse !== 0) begin
                errs++;
                $display("FAIL glitch_accepted: iter=%0d out=%h cut=%h mend=%h", r, wire_out, cut_pulse, mend_pulse);
            end
            if (r == 0) begin
                vec++;
                if (glitch_cnt !== 8'd1) begin
                    errs++;
                    $display("FAIL glitch_one: gc=%0d, need 1", glitch_cnt);
                end
            end
        end
        vec++;
        if (glitch_cnt !== 8'd255) begin
            errs++;
            $display("FAIL glitch_sat: gc=%0d, need 255", glitch_cnt);
        end
        pulse_clr();
    endtask

    task automatic test_same_cycle();
        int t;
        pulse_clr();
        arm = 1'b1;
        wire_in[4] = 1'b0; wire_in[1] = 1'b0;
        t = 0;
        while (cut_pulse == 0 && t < 20) begin step(); t++; end
        vec++;
        if (cut_pulse !== 6'h12) begin
            errs++;
            $display("FAIL dual_cut_pulse: cut=%h, need 12", cut_pulse);
        end
        step();
        vec++;
        if (cut_mask !== 6'h12 || first_cut_valid !== 1 || first_cut_idx !== 3'd1) begin
            errs++;
            $display("FAIL dual_cut_latch: mask=%h fv=%b idx=%0d, need 12/1/1", cut_mask, first_cut_valid, first_cut_idx);
        end
        wire_in[4] = 1'b1;
        t = 0;
        while (mend_pulse == 0 && t < 20) begin step(); t++; end
        vec++;
        if (mend_pulse !== 6'h10 || cut_mask !== 6'h12) begin
            errs++;
            $display("FAIL mend_pulse: mend=%h mask=%h, need 10/12", mend_pulse, cut_mask);
        end
        wire_in[1] = 1'b1;
        step(10);
        pulse_clr();
    endtask

    task automatic test_arm_clr();
        int t;
        arm = 1'b0;
        wire_in[5] = 1'b0;
        t = 0;
        while (cut_pulse == 0 && t < 20) begin step(); t++; end
        vec++;
        if (cut_pulse !== 6'h20) begin
            errs++;
            $display("FAIL unarmed_pulse: cut=%h, need 20", cut_pulse);
        end
        step();
        vec++;
        if (cut_mask !== 0 || first_cut_valid !== 0) begin
            errs++;
            $display("FAIL unarmed_latch: mask=%h fv=%b, need 00/0", cut_mask, first_cut_valid);
        end
        arm = 1'b1;
        wire_in[3] = 1'b0;
        t = 0;
        while (cut_pulse == 0 && t < 20) begin step(); t++; end
        clr = 1'b1;
        step();
        clr = 1'b0;
        vec++;
        if (cut_mask !== 0 || first_cut_valid !== 0 || first_cut_idx !== 0 || glitch_cnt !== 0) begin
            errs++;
            $display("FAIL clr_priority: mask=%h fv=%b idx=%0d gc=%0d, need 0/0/0/0",
                     cut_mask, first_cut_valid, first_cut_idx, glitch_cnt);
        end
        step(2);
        vec++;
        if (cut_mask !== 0 || wire_out !== 6'h17) begin
            errs++;
            $display("FAIL clr_after: mask=%h out=%h, need 00/17", cut_mask, wire_out);
        end
        wire_in = 6'h3F;
        step(10);
        pulse_clr();
    endtask

    task automatic test_reset_mid();
        arm = 1'b1;
        wire_in[2] = 1'b0;
        step(5);
        rst = 1'b0;
        step();
        vec++;
        if (wire_out !== 6'h3F || cut_pulse !== 0 || cut_mask !== 0 || glitch_cnt !== 0) begin
            errs++;
            $display("FAIL mid_reset: out=%h cut=%h mask=%h gc=%0d, need 3f/0/0/0", wire_out, cut_pulse, cut_mask, glitch_cnt);
        end
        rst = 1'b1;
        step();
        vec++;
        if (cut_pulse !== 0 || mend_pulse !== 0 || wire_out !== 6'h3F) begin
            errs++;
            $display("FAIL first_cycle: cut=%h mend=%h out=%h, need 0/0/3f", cut_pulse, mend_pulse, wire_out);
        end
        step(4);
        vec++;
        if (wire_out !== 6'h3F) begin
            errs++;
            $display("FAIL refilter_early: out=%h, need 3f", wire_out);
        end
        step();
        vec++;
        if (wire_out !== 6'h3B || cut_pulse !== 6'h04) begin
            errs++;
            $display("FAIL refilter_done: out=%h cut=%h, need 3b/04", wire_out, cut_pulse);
        end
        wire_in = 6'h3F;
        step(10);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) wire_in[i] = ~wire_in[i];
            arm = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 499) != 0);
            step();
            vec++;
            if (wire_out !== m_lvl_vec() || cut_pulse !== m_cut || mend_pulse !== m_mend) begin
                errs++;
                $display("FAIL rand_filter: cyc=%0d out=%h cut=%h mend=%h, need %h/%h/%h",
                         k, wire_out, cut_pulse, mend_pulse, m_lvl_vec(), m_cut, m_mend);
            end
            vec++;
            if (cut_mask !== m_mask || first_cut_valid !== m_fv ||
                first_cut_idx !== 3'(m_idx) || glitch_cnt !== GW'(m_gc)) begin
                errs++;
                $display("FAIL rand_status: cyc=%0d mask=%h fv=%b idx=%0d gc=%0d, need %h/%b/%0d/%0d",
                         k, cut_mask, first_cut_valid, first_cut_idx, glitch_cnt, m_mask, m_fv, m_idx, m_gc);
            end
        end
    endtask

    function automatic bit [N-1:0] m_lvl_vec();
        bit [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_lvl[i];
        return v;
    endfunction

    initial begin
        test_reset();
        test_single_cut();
        test_glitch();
        test_same_cycle();
        test_arm_clr();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
